// File: rtl/game_session_ctrl.sv
// ============================================================================
// game_session_ctrl
//
// Session controller for a timed quiz game. Runs the round loop
// (level set-up, timer reconfiguration, play, judging, advancing) and keeps
// a per-player save slot in an external RAM through a req/ack handshake.
//
// Optional feature macro: GAME_SESSION_LEVEL_BONUS_EN
//   defined   : advancing a level adds 10*level (pre-increment) to the
//               score, saturating at the top of the score range.
//   undefined : advancing a level leaves the score unchanged.
//
// Ports
//   i_clk            single clock, all state on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_logged_in      player session active
//   i_player_id      current save slot, sampled when a save/restore starts
//   i_start_btn      start a round / restart after game over (pulse)
//   i_save_btn       save the session (pulse)
//   i_answer_ok      correct answer during play (pulse)
//   i_time_out       round timer expired during play (pulse)
//   i_ram_rdata      slot record {level, count, score}, valid with i_ram_ack
//   i_ram_ack        completes the pending RAM request
//   o_ram_req        RAM request
//   o_ram_we         1 = write, 0 = read
//   o_ram_addr       slot address
//   o_ram_wdata      record written on save
//   o_timer_reconfig one-cycle pulse to reload the round timer
//   o_timer_enable   round timer running
//   o_load_rng       one-cycle pulse to draw a new question
//   o_time_limit     round time for the current level
//   o_level          current level
//   o_score          current score
//   o_meter          thermometer display of the miss count
//   o_game_over      session ended
//   o_game_won       session ended past the last playable level
// ============================================================================
module game_session_ctrl #(
    parameter int NUM_PLAYERS = 4,
    parameter int NUM_LEVELS  = 3,
    parameter int LED_W       = 10,
    parameter int SCORE_W     = 7,
    parameter int BASE_TIME   = 40,
    localparam int PID_W  = $clog2(NUM_PLAYERS),
    localparam int LVL_W  = $clog2(NUM_LEVELS + 2),
    localparam int CNT_W  = $clog2(LED_W + 1),
    localparam int DATA_W = LVL_W + CNT_W + SCORE_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_logged_in,
    input  logic [PID_W-1:0]  i_player_id,
    input  logic              i_start_btn,
    input  logic              i_save_btn,
    input  logic              i_answer_ok,
    input  logic              i_time_out,
    input  logic [DATA_W-1:0] i_ram_rdata,
    input  logic              i_ram_ack,
    output logic              o_ram_req,
    output logic              o_ram_we,
    output logic [PID_W-1:0]  o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_timer_reconfig,
    output logic              o_timer_enable,
    output logic              o_load_rng,
    output logic [6:0]        o_time_limit,
    output logic [LVL_W-1:0]  o_level,
    output logic [SCORE_W-1:0] o_score,
    output logic [LED_W-1:0]  o_meter,
    output logic              o_game_over,
    output logic              o_game_won
);

    localparam logic [SCORE_W-1:0] START_SCORE = SCORE_W'(51);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
    localparam int                 MIN_TIME    = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RESTORE,
        ST_LEVEL_SET,
        ST_RECONFIG,
        ST_READY,
        ST_PLAY,
        ST_JUDGE,
        ST_ADVANCE,
        ST_OVER,
        ST_SAVE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [LVL_W-1:0]    r_level, w_level_nxt;
    logic [CNT_W-1:0]    r_count, w_count_nxt;
    logic [SCORE_W-1:0]  r_score, w_score_nxt;
    logic [NUM_PLAYERS-1:0] r_valid, w_valid_nxt;
    logic [PID_W-1:0]    r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;

    logic                w_load_rng;
    logic [LVL_W-1:0]    w_rd_level;
    logic [CNT_W-1:0]    w_rd_count;
    logic [SCORE_W-1:0]  w_rd_score;
    logic                w_rd_level_ok;
    logic [SCORE_W-1:0]  w_score_adv;
    logic [SCORE_W-1:0]  w_score_inc;
    logic [SCORE_W-1:0]  w_score_dec;
    logic [LED_W:0]      w_therm;
    int                  w_time;

    // Starting miss count of a level: 4 at level 1, two more per level,
    // capped one below a full meter so a fresh level never starts lost.
    function automatic logic [CNT_W-1:0] levelCount(input logic [LVL_W-1:0] lvl);
        int c;
        c = 4 + 2 * (int'(lvl) - 1);
        if (c > LED_W - 1) c = LED_W - 1;
        if (c < 0) c = 0;
        return CNT_W'(c);
    endfunction

    assign w_rd_level    = i_ram_rdata[DATA_W-1 -: LVL_W];
    assign w_rd_count    = i_ram_rdata[SCORE_W +: CNT_W];
    assign w_rd_score    = i_ram_rdata[SCORE_W-1:0];
    assign w_rd_level_ok = (w_rd_level >= LVL_W'(1)) && (w_rd_level <= LVL_W'(NUM_LEVELS));

    assign w_score_inc = (r_score != SCORE_MAX)      ? r_score + SCORE_W'(1) : r_score;
    assign w_score_dec = (r_score != SCORE_W'(0))    ? r_score - SCORE_W'(1) : r_score;

`ifdef GAME_SESSION_LEVEL_BONUS_EN
    // Level-clear bonus, computed wide and clamped to the score range.
    int w_bonus_sum;
    always_comb begin
        w_bonus_sum = int'(r_score) + 10 * int'(r_level);
        w_score_adv = (w_bonus_sum > int'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(w_bonus_sum);
    end
`else
    assign w_score_adv = r_score;
`endif

    // Round time shrinks by 10 per level but never below the floor.
    always_comb begin
        w_time = BASE_TIME - 10 * (int'(r_level) - 1);
        if (w_time < MIN_TIME) w_time = MIN_TIME;
    end

    assign w_therm = ((LED_W+1)'(1) << r_count) - (LED_W+1)'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_level <= LVL_W'(1);
            r_count <= '0;
            r_score <= START_SCORE;
            r_valid <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_count <= w_count_nxt;
            r_score <= w_score_nxt;
            r_valid <= w_valid_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_count_nxt = r_count;
        w_score_nxt = r_score;
        w_valid_nxt = r_valid;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_load_rng  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_logged_in) begin
                    if (r_valid[i_player_id]) begin
                        w_addr_nxt  = i_player_id;
                        w_state_nxt = ST_RESTORE;
                    end else begin
                        w_state_nxt = ST_LEVEL_SET;
                    end
                end
            end

            // A record with an unplayable level is treated as a fresh start.
            ST_RESTORE: begin
                if (i_ram_ack) begin
                    if (w_rd_level_ok) begin
                        w_level_nxt = w_rd_level;
                        w_count_nxt = w_rd_count;
                        w_score_nxt = w_rd_score;
                    end else begin
                        w_level_nxt = LVL_W'(1);
                        w_count_nxt = levelCount(LVL_W'(1));
                        w_score_nxt = START_SCORE;
                    end
                    w_valid_nxt[r_addr] = 1'b0;
                    w_state_nxt         = ST_RECONFIG;
                end
            end

            ST_LEVEL_SET: begin
                w_count_nxt = levelCount(r_level);
                if (r_level == LVL_W'(1)) w_score_nxt = START_SCORE;
                w_state_nxt = ST_RECONFIG;
            end

            ST_RECONFIG: begin
                w_state_nxt = ST_READY;
            end

            ST_READY: begin
                if (i_save_btn) begin
                    w_addr_nxt  = i_player_id;
                    w_wdata_nxt = {r_level, r_count, r_score};
                    w_state_nxt = ST_SAVE;
                end else if (i_start_btn) begin
                    w_load_rng  = 1'b1;
                    w_state_nxt = ST_PLAY;
                end
            end

            // A correct answer outranks a simultaneous timeout.
            ST_PLAY: begin
                if (i_answer_ok) begin
                    if (r_count != CNT_W'(0)) w_count_nxt = r_count - CNT_W'(1);
                    w_score_nxt = w_score_inc;
                    w_state_nxt = ST_JUDGE;
                end else if (i_time_out) begin
                    if (r_count < CNT_W'(LED_W)) w_count_nxt = r_count + CNT_W'(1);
                    w_score_nxt = w_score_dec;
                    w_state_nxt = ST_JUDGE;
                end
            end

            ST_JUDGE: begin
                if (r_count == CNT_W'(0))          w_state_nxt = ST_ADVANCE;
                else if (r_count == CNT_W'(LED_W)) w_state_nxt = ST_OVER;
                else                               w_state_nxt = ST_RECONFIG;
            end

            ST_ADVANCE: begin
                w_level_nxt = r_level + LVL_W'(1);
                w_score_nxt = w_score_adv;
                if (r_level == LVL_W'(NUM_LEVELS)) w_state_nxt = ST_OVER;
                else                               w_state_nxt = ST_LEVEL_SET;
            end

            ST_OVER: begin
                if (i_save_btn) begin
                    w_addr_nxt  = i_player_id;
                    w_wdata_nxt = {r_level, r_count, r_score};
                    w_state_nxt = ST_SAVE;
                end else if (i_start_btn) begin
                    w_level_nxt = LVL_W'(1);
                    w_state_nxt = ST_LEVEL_SET;
                end
            end

            ST_SAVE: begin
                if (i_ram_ack) begin
                    w_valid_nxt[r_addr] = 1'b1;
                    w_state_nxt         = ST_IDLE;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase

        // Logging out abandons the game, but a RAM transfer in flight is
        // allowed to finish so the handshake is never left half-done.
        if (!i_logged_in && (r_state != ST_SAVE) && (r_state != ST_RESTORE)) begin
            w_state_nxt = ST_IDLE;
            w_load_rng  = 1'b0;
        end
    end

    assign o_ram_req        = (r_state == ST_SAVE) || (r_state == ST_RESTORE);
    assign o_ram_we         = (r_state == ST_SAVE);
    assign o_ram_addr       = r_addr;
    assign o_ram_wdata      = r_wdata;
    assign o_timer_reconfig = (r_state == ST_RECONFIG);
    assign o_timer_enable   = (r_state == ST_PLAY);
    assign o_load_rng       = w_load_rng;
    assign o_time_limit     = 7'(w_time);
    assign o_level          = r_level;
    assign o_score          = r_score;
    assign o_meter          = w_therm[LED_W-1:0];
    assign o_game_over      = (r_state == ST_OVER);
    assign o_game_won       = (r_state == ST_OVER) && (r_level == LVL_W'(NUM_LEVELS + 1));

endmodule

// File: tb/tb_game_session_ctrl.sv
// ============================================================================
// tb_game_session_ctrl
//
// Directed self-checking bench for game_session_ctrl with default
// parameters (4 players, 3 levels, 10-LED meter, 7-bit score).
// Expected values are hand-computed; the level-clear bonus expectations
// follow GAME_SESSION_LEVEL_BONUS_EN when it is defined for the build.
// ============================================================================
module tb_game_session_ctrl;

`ifdef GAME_SESSION_LEVEL_BONUS_EN
    localparam int SCORE_L2   = 65;
    localparam int SCORE_WON  = 127;
`else
    localparam int SCORE_L2   = 55;
    localparam int SCORE_WON  = 101;
`endif

    logic        clk;
    logic        rst_n;
    logic        loggedIn;
    logic [1:0]  playerId;
    logic        startBtn;
    logic        saveBtn;
    logic        answerOk;
    logic        timeOut;
    logic [13:0] ramRdata;
    logic        ramAck;
    logic        ramReq;
    logic        ramWe;
    logic [1:0]  ramAddr;
    logic [13:0] ramWdata;
    logic        timerReconfig;
    logic        timerEnable;
    logic        loadRng;
    logic [6:0]  timeLimit;
    logic [2:0]  level;
    logic [6:0]  score;
    logic [9:0]  meter;
    logic        gameOver;
    logic        gameWon;

    int numChecks = 0;
    int numPassed = 0;
    logic [13:0] savedRec;

    game_session_ctrl dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_logged_in      (loggedIn),
        .i_player_id      (playerId),
        .i_start_btn      (startBtn),
        .i_save_btn       (saveBtn),
        .i_answer_ok      (answerOk),
        .i_time_out       (timeOut),
        .i_ram_rdata      (ramRdata),
        .i_ram_ack        (ramAck),
        .o_ram_req        (ramReq),
        .o_ram_we         (ramWe),
        .o_ram_addr       (ramAddr),
        .o_ram_wdata      (ramWdata),
        .o_timer_reconfig (timerReconfig),
        .o_timer_enable   (timerEnable),
        .o_load_rng       (loadRng),
        .o_time_limit     (timeLimit),
        .o_level          (level),
        .o_score          (score),
        .o_meter          (meter),
        .o_game_over      (gameOver),
        .o_game_won       (gameWon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            numPassed++;
    endtask

    // Drive one-cycle button pulses across a single clock edge.
    task automatic applyStimulus(input logic st, input logic sv, input logic ans, input logic tout);
        startBtn = st;
        saveBtn  = sv;
        answerOk = ans;
        timeOut  = tout;
        tick();
        startBtn = 1'b0;
        saveBtn  = 1'b0;
        answerOk = 1'b0;
        timeOut  = 1'b0;
    endtask

    // From READY: start, one play event, then leave JUDGE.
    task automatic playRound(input logic ans, input logic tout);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, ans, tout);
        tick();
    endtask

    // From READY/OVER: save into a slot with immediate ack, then restore
    // the given record back from that slot. Ends in RECONFIG.
    task automatic saveRestore(input logic [1:0] pid, input logic [13:0] rec);
        playerId = pid;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        ramAck = 1'b1;
        tick();
        ramAck = 1'b0;
        tick();
        ramRdata = rec;
        ramAck   = 1'b1;
        tick();
        ramAck   = 1'b0;
        ramRdata = '0;
    endtask

    initial begin
        rst_n    = 1'b1;
        loggedIn = 1'b0;
        playerId = 2'd0;
        startBtn = 1'b0;
        saveBtn  = 1'b0;
        answerOk = 1'b0;
        timeOut  = 1'b0;
        ramRdata = '0;
        ramAck   = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_level",    32'(level),    32'd1);
        checkOutput("rst_score",    32'(score),    32'd51);
        checkOutput("rst_meter",    32'(meter),    32'h0);
        checkOutput("rst_over",     32'(gameOver), 32'd0);
        checkOutput("rst_req",      32'(ramReq),   32'd0);
        checkOutput("rst_addr",     32'(ramAddr),  32'd0);
        checkOutput("rst_wdata",    32'(ramWdata), 32'd0);
        checkOutput("rst_tenable",  32'(timerEnable), 32'd0);
        tick();
        rst_n = 1'b1;

        // Fresh login, no saved slot: level 1 set-up.
        loggedIn = 1'b1;
        tick();
        tick();
        checkOutput("l1_meter",     32'(meter),     32'h00F);
        checkOutput("l1_tlimit",    32'(timeLimit), 32'd40);
        checkOutput("l1_score",     32'(score),     32'd51);
        checkOutput("l1_reconfig",  32'(timerReconfig), 32'd1);
        tick();
        checkOutput("ready_reconfig", 32'(timerReconfig), 32'd0);

        // First round by hand to observe the RNG/timer handshake.
        startBtn = 1'b1;
        #1;
        checkOutput("load_rng",     32'(loadRng),   32'd1);
        tick();
        startBtn = 1'b0;
        checkOutput("play_tenable", 32'(timerEnable), 32'd1);
        answerOk = 1'b1;
        tick();
        answerOk = 1'b0;
        checkOutput("judge_tenable", 32'(timerEnable), 32'd0);
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            playRound(1'b1, 1'b0);
            tick();
        end
        checkOutput("l1_cnt1_meter", 32'(meter), 32'h001);
        checkOutput("l1_cnt1_score", 32'(score), 32'd54);

        // Fourth correct answer clears the level.
        playRound(1'b1, 1'b0);
        checkOutput("adv_meter",    32'(meter),     32'h000);
        tick();
        checkOutput("l2_level",     32'(level),     32'd2);
        checkOutput("l2_tlimit",    32'(timeLimit), 32'd30);
        checkOutput("l2_score",     32'(score),     32'(SCORE_L2));
        tick();
        checkOutput("l2_meter",     32'(meter),     32'h03F);
        tick();

        // Answer and timeout together: the answer wins.
        playRound(1'b1, 1'b1);
        checkOutput("both_meter",   32'(meter),     32'h01F);
        checkOutput("both_score",   32'(score),     32'(SCORE_L2 + 1));
        tick();

        // Save to slot 2 with a slow RAM; logout mid-save must not abort it.
        savedRec = {3'd2, 4'd5, 7'(SCORE_L2 + 1)};
        playerId = 2'd2;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        playerId = 2'd0;
        loggedIn = 1'b0;
        checkOutput("save_we",      32'(ramWe),     32'd1);
        for (int k = 0; k < 5; k++) begin
            checkOutput("save_req_held",  32'(ramReq),   32'd1);
            checkOutput("save_addr_held", 32'(ramAddr),  32'd2);
            checkOutput("save_data_held", 32'(ramWdata), 32'(savedRec));
            tick();
        end
        ramAck = 1'b1;
        checkOutput("save_req_ack", 32'(ramReq),    32'd1);
        tick();
        ramAck = 1'b0;
        checkOutput("save_done_req", 32'(ramReq),   32'd0);
        tick();
        checkOutput("logout_idle_req", 32'(ramReq), 32'd0);

        // Relogin on slot 2 restores the record.
        loggedIn = 1'b1;
        playerId = 2'd2;
        tick();
        checkOutput("rest_req",     32'(ramReq),    32'd1);
        checkOutput("rest_we",      32'(ramWe),     32'd0);
        checkOutput("rest_addr",    32'(ramAddr),   32'd2);
        ramRdata = savedRec;
        ramAck   = 1'b1;
        tick();
        ramAck   = 1'b0;
        ramRdata = '0;
        checkOutput("rest_level",   32'(level),     32'd2);
        checkOutput("rest_meter",   32'(meter),     32'h01F);
        checkOutput("rest_score",   32'(score),     32'(SCORE_L2 + 1));

        // Logout and back in: the slot was consumed, so no second restore.
        loggedIn = 1'b0;
        tick();
        checkOutput("logout_reconfig", 32'(timerReconfig), 32'd0);
        loggedIn = 1'b1;
        tick();
        checkOutput("noslot_req",   32'(ramReq),    32'd0);
        tick();
        checkOutput("noslot_meter", 32'(meter),     32'h03F);
        checkOutput("noslot_score", 32'(score),     32'(SCORE_L2 + 1));
        tick();

        // Restore level 3 with one miss left, then clear the last level.
        saveRestore(2'd1, {3'd3, 4'd1, 7'd100});
        checkOutput("l3_level",     32'(level),     32'd3);
        checkOutput("l3_tlimit",    32'(timeLimit), 32'd20);
        tick();
        playRound(1'b1, 1'b0);
        tick();
        checkOutput("won_over",     32'(gameOver),  32'd1);
        checkOutput("won_won",      32'(gameWon),   32'd1);
        checkOutput("won_level",    32'(level),     32'd4);
        checkOutput("won_tlimit",   32'(timeLimit), 32'd10);
        checkOutput("won_score",    32'(score),     32'(SCORE_WON));

        // Restart from game over.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("restart_level", 32'(level),    32'd1);
        checkOutput("restart_score", 32'(score),    32'd51);
        checkOutput("restart_over",  32'(gameOver), 32'd0);
        tick();

        // Six timeouts from count 4 fill the meter and end the game.
        for (int i = 0; i < 5; i++) begin
            playRound(1'b0, 1'b1);
            tick();
        end
        playRound(1'b0, 1'b1);
        checkOutput("lost_meter",   32'(meter),     32'h3FF);
        checkOutput("lost_score",   32'(score),     32'd45);
        checkOutput("lost_over",    32'(gameOver),  32'd1);
        checkOutput("lost_won",     32'(gameWon),   32'd0);

        // Score floor: a timeout at score 0 keeps it at 0.
        saveRestore(2'd3, {3'd1, 4'd4, 7'd0});
        tick();
        playRound(1'b0, 1'b1);
        checkOutput("floor_score",  32'(score),     32'd0);
        checkOutput("floor_meter",  32'(meter),     32'h01F);
        tick();

        // A record with level 0 restarts at level 1 defaults.
        saveRestore(2'd0, {3'd0, 4'd9, 7'd3});
        checkOutput("badlvl_level", 32'(level),     32'd1);
        checkOutput("badlvl_meter", 32'(meter),     32'h00F);
        checkOutput("badlvl_score", 32'(score),     32'd51);
        tick();

        // Reset during SAVE drops the request at once; a late ack is ignored.
        playerId = 2'd2;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rsave_req_pre", 32'(ramReq),   32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rsave_req_drop", 32'(ramReq),  32'd0);
        loggedIn = 1'b0;
        ramAck   = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("late_ack_req", 32'(ramReq),    32'd0);
        ramAck   = 1'b0;
        loggedIn = 1'b1;
        tick();
        checkOutput("post_rst_noslot", 32'(ramReq), 32'd0);

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule

// File: doc/game_session_ctrl.md
GAME_SESSION_CTRL -- requirements
Module: game_session_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 4, number of save slots; PID_W = clog2(NUM_PLAYERS).
REQ-002 SHALL have parameter NUM_LEVELS, default 3, last playable level; LVL_W = clog2(NUM_LEVELS+2).
REQ-003 SHALL have parameter LED_W, default 10, meter bar width; CNT_W = clog2(LED_W+1).
REQ-004 SHALL have parameter SCORE_W, default 7, score width; START_SCORE = 51, saturating arithmetic.
REQ-005 SHALL have parameter BASE_TIME, default 40, level-1 time limit; lower bound MIN_TIME = 5; DATA_W = LVL_W+CNT_W+SCORE_W.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 logged_in  in  1  player session active; start/save ignored when 0.
REQ-009 player_id  in  PID_W  current slot; sampled at save/restore start.
REQ-010 start_btn, save_btn, answer_ok, time_out  in  1 each  single-cycle pulses.
REQ-011 ram_rdata  in  DATA_W  slot read data, valid in the ram_ack cycle.
REQ-012 ram_ack  in  1  completes the pending ram_req.
REQ-013 ram_req, ram_we  out  1 each  RAM request / 1 = write.
REQ-014 ram_addr  out  PID_W;  ram_wdata  out  DATA_W  record {level, count, score}.
REQ-015 timer_reconfig, timer_enable, load_rng  out  1 each  to round timer / RNG.
REQ-016 time_limit  out  7  max(BASE_TIME-10*(level-1), MIN_TIME).
REQ-017 level  out  LVL_W;  score  out  SCORE_W;  meter  out  LED_W  thermometer of count, i.e. (1<<count)-1.
REQ-018 game_over  out  1  high in OVER; game_won  out  1  high in OVER when level == NUM_LEVELS+1.

Function
REQ-019 States: IDLE, RESTORE, LEVEL_SET, RECONFIG, READY, PLAY, JUDGE, ADVANCE, OVER, SAVE.
REQ-020 IDLE: when logged_in=1 and valid[player_id]=1 -> RESTORE; when logged_in=1 otherwise -> LEVEL_SET; else stay.
REQ-021 RESTORE: assert ram_req=1, ram_we=0, ram_addr=player_id until ram_ack; on ack load level/count/score from ram_rdata, clear valid[player_id] -> RECONFIG; restored level outside 1..NUM_LEVELS -> level=1, count and score take their level-1 values.
REQ-022 LEVEL_SET: count = min(4+2*(level-1), LED_W-1); score = START_SCORE when level==1 -> RECONFIG.
REQ-023 RECONFIG: timer_reconfig=1 for exactly one cycle -> READY.
REQ-024 READY: save_btn -> SAVE (priority over start_btn); start_btn -> PLAY with load_rng=1 and timer_enable=1 for one cycle.
REQ-025 PLAY: answer_ok -> count-1, score+1; else time_out -> count+1, score-1; both in one cycle -> answer_ok wins; then -> JUDGE with timer_enable=0.
REQ-026 JUDGE: count==0 -> ADVANCE; count==LED_W -> OVER; else -> RECONFIG.
REQ-027 ADVANCE: level+1 -> OVER when the new level == NUM_LEVELS+1, else -> LEVEL_SET.
REQ-028 OVER: save_btn -> SAVE; start_btn -> level=1, LEVEL_SET.
REQ-029 SAVE: ram_req=1, ram_we=1, ram_addr=player_id captured on entry, ram_wdata={level,count,score} held stable until ram_ack; on ack set valid[slot] -> IDLE.
REQ-030 Score saturates at 0 and 2^SCORE_W-1; count never wraps.
REQ-031 logged_in falling in any state except SAVE/RESTORE -> IDLE next cycle with timers off; SAVE/RESTORE complete first.

Reset
REQ-032 rst=0 asynchronously: state=IDLE, level=1, score=START_SCORE, count=0, valid=0, all single-bit outputs 0, ram_addr=0, ram_wdata=0.
REQ-033 Reset mid-handshake drops ram_req immediately; late ram_ack after reset is ignored.

Configuration
REQ-034 Macro GAME_SESSION_LEVEL_BONUS_EN defined: ADVANCE adds 10*level (level before increment) to score, saturating.
REQ-035 Macro undefined: ADVANCE leaves score unchanged; no other difference.

Verification
REQ-036 Reset, logged_in=1 with no saved slot -> LEVEL_SET, count=4, meter=0x00F, time_limit=40, score=51.
REQ-037 4 answer_ok pulses at level 1 -> ADVANCE, level=2, count=6, time_limit=30; with macro score=65, without score=55.
REQ-038 6 time_out pulses from count=4 -> count=10, meter=0x3FF, game_over=1, score=45.
REQ-039 answer_ok and time_out in the same cycle -> count-1, score+1.
REQ-040 save_btn in READY, player_id=2, ram_ack delayed 5 cycles -> ram_req held 5 cycles with stable addr=2 and data; relogin -> restored values, valid[2]=0.
REQ-041 Score at 0 with time_out -> score stays 0; reset asserted during SAVE -> ram_req=0 in the same cycle.
